mux2_rr_arbiter: RTL and testbench
==================================

Name: mux2_rr_arbiter

Overview:
- Shares one 4-bit output channel between two requesters, each with a val/rdy handshake.
- Round-robin arbitration. The existing 2:1 4-bit mux steers the winning request's data into a one-entry pipelined output buffer.
- Per-requester grant counters are exposed for performance monitoring.
- Sits between two message producers and a single downstream consumer.

Parameters:
p_count_nbits, 8, width of each grant counter (wraps modulo 2^p_count_nbits)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in0_val  input  1  requester 0 has a valid message
in0_rdy  output  1  requester 0 message accepted this cycle
in0_msg  input  4  requester 0 data
in1_val  input  1  requester 1 has a valid message
in1_rdy  output  1  requester 1 message accepted this cycle
in1_msg  input  4  requester 1 data
out_val  output  1  output buffer holds a valid message
out_rdy  input  1  consumer accepts the output message
out_msg  output  4  buffered message
grant_count0  output  p_count_nbits  accepted transfers from requester 0
grant_count1  output  p_count_nbits  accepted transfers from requester 1

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high.
- Reset values: out_val=0, out_msg=4'b0000, prio=0 (requester 0 favoured), grant_count0=0, grant_count1=0. Reset overrides any concurrent transfer.
- State:
  - buf_val (drives out_val).
  - buf_msg (drives out_msg).
  - prio (1 bit; index of the favoured requester).
  - Two counters.
- can_accept = !buf_val || out_rdy (pipelined: enqueue permitted in the same cycle as dequeue).
- Grant (combinational):
  - Both valid: grant = prio.
  - Only one valid: grant = that requester.
  - Neither valid: no grant.
- inN_rdy = can_accept && inN_val && (grant==N). Never more than one rdy high per cycle. rdy depends combinationally on in*_val and out_rdy; producers must not make val depend on rdy.
- Mux sel = grant. When no request is present, sel holds prio, and the mux output is ignored.
- Transfer on requester N (inN_val && inN_rdy):
  - buf_msg <= selected msg; buf_val <= 1.
  - prio <= ~N, so the other requester is favoured next.
  - grant_countN increments by 1, wrapping from 2^p_count_nbits-1 to 0.
- Dequeue only (out_val && out_rdy, no transfer): buf_val <= 0; buf_msg holds its old value.
- Neither transfer nor dequeue: all state holds. prio changes only on a transfer.
- Latency: one cycle from input transfer to out_val. Full throughput of 1 msg/cycle when out_rdy is held high. With both requesters continuously valid, grants strictly alternate.
- Backpressure: buffer full and out_rdy=0 gives in0_rdy=in1_rdy=0; out_msg stays stable while out_val=1 and out_rdy=0.
- Reset mid-operation: a buffered message is discarded and no counter increments in the reset cycle. The first grant after reset goes to requester 0 if both are valid.

Decomposition:
- Shared package: the message width constant (4) and the requester-index constants REQ0=0 and REQ1=1.
- Sub-module: instantiate the existing 2:1 4-bit mux for the datapath.
- Arbitration, buffer, priority and counters stay in this module.

Test Plan:
1. Reset, then in0_val=1, in0_msg=4'b1010, in1_val=0, out_rdy=1 -> in0_rdy=1 in the same cycle; next cycle out_val=1, out_msg=4'b1010, grant_count0=1, prio=1.
2. From reset, both valid (in0_msg=4'b1110, in1_msg=4'b0111), out_rdy=1 for 4 cycles -> out_msg sequence 1110, 0111, 1110, 0111; grant_count0=2, grant_count1=2.
3. Buffer full and out_rdy=0 with both inputs valid -> in0_rdy=in1_rdy=0, out_msg stable, counters unchanged for 3 cycles. Then out_rdy=1 -> dequeue and new enqueue in the same cycle, out_val remains 1.
4. Only in1 valid for 3 transfers, then both valid -> the first contested grant goes to requester 0, since prio=0 after the last in1 transfer.
5. Drive 256 requester-0 transfers -> grant_count0 wraps to 0 (p_count_nbits=8).
6. Assert reset while out_val=1 and a transfer is pending -> next cycle out_val=0, out_msg=0, counters=0; the pending transfer is not counted.

Source files
------------

// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared constants for the two-requester round-robin arbiter.
package mux2_rr_arbiter_pkg;

  // Message payload width carried on every channel.
  localparam int MSG_W = 4;

  // Requester indices; also the encoding of the mux select and of prio.
  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/mux2_rr_arbiter_mux2.sv
// 2:1 message mux steering the selected requester's payload to the buffer.
module mux2_rr_arbiter_mux2
  import mux2_rr_arbiter_pkg::*;
(
  input  logic [MSG_W-1:0] i_in0,
  input  logic [MSG_W-1:0] i_in1,
  input  logic             i_sel,
  output logic [MSG_W-1:0] o_out
);

  // Pure combinational select; sel == REQ1 picks input 1.
  always_comb begin
    o_out = (i_sel == REQ1) ? i_in1 : i_in0;
  end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one 4-bit channel between two val/rdy
// requesters, with a one-entry pipelined output buffer and grant counters.
module mux2_rr_arbiter
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int p_count_nbits = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in0_val,
  output logic                     in0_rdy,
  input  logic [MSG_W-1:0]         in0_msg,
  input  logic                     in1_val,
  output logic                     in1_rdy,
  input  logic [MSG_W-1:0]         in1_msg,
  output logic                     out_val,
  input  logic                     out_rdy,
  output logic [MSG_W-1:0]         out_msg,
  output logic [p_count_nbits-1:0] grant_count0,
  output logic [p_count_nbits-1:0] grant_count1
);

  logic                     r_buf_val;
  logic [MSG_W-1:0]         r_buf_msg;
  logic                     r_prio;
  logic [p_count_nbits-1:0] r_cnt0;
  logic [p_count_nbits-1:0] r_cnt1;

  logic                     w_can_accept;
  logic                     w_sel;
  logic                     w_xfer0;
  logic                     w_xfer1;
  logic [MSG_W-1:0]         w_mux_out;

  // Grant selection: contested or idle cycles follow prio, otherwise the
  // lone valid requester wins. Idle-cycle select is don't-care downstream.
  always_comb begin
    w_can_accept = !r_buf_val || out_rdy;
    if (in0_val && in1_val) w_sel = r_prio;
    else if (in1_val)       w_sel = REQ1;
    else if (in0_val)       w_sel = REQ0;
    else                    w_sel = r_prio;
    w_xfer0 = w_can_accept && in0_val && (w_sel == REQ0);
    w_xfer1 = w_can_accept && in1_val && (w_sel == REQ1);
  end

  mux2_rr_arbiter_mux2 u_mux (
    .i_in0 (in0_msg),
    .i_in1 (in1_msg),
    .i_sel (w_sel),
    .o_out (w_mux_out)
  );

  // Output buffer and priority: load on a transfer, drain on dequeue only.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf_val <= 1'b0;
      r_buf_msg <= '0;
      r_prio    <= REQ0;
    end else if (w_xfer0 || w_xfer1) begin
      r_buf_val <= 1'b1;
      r_buf_msg <= w_mux_out;
      r_prio    <= ~w_sel;
    end else if (out_rdy) begin
      r_buf_val <= 1'b0;
    end
  end

  // Per-requester grant counters, wrapping modulo 2^p_count_nbits.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt0 <= '0;
      r_cnt1 <= '0;
    end else begin
      if (w_xfer0) r_cnt0 <= r_cnt0 + p_count_nbits'(1);
      if (w_xfer1) r_cnt1 <= r_cnt1 + p_count_nbits'(1);
    end
  end

  assign in0_rdy      = w_xfer0;
  assign in1_rdy      = w_xfer1;
  assign out_val      = r_buf_val;
  assign out_msg      = r_buf_msg;
  assign grant_count0 = r_cnt0;
  assign grant_count1 = r_cnt1;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Scoreboard bench for mux2_rr_arbiter: accepted messages are queued at
// the input handshake and compared when they appear on the output.
module tb_mux2_rr_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       in0_val, in1_val, out_rdy;
  logic [3:0] in0_msg, in1_msg;
  logic       in0_rdy, in1_rdy, out_val;
  logic [3:0] out_msg;
  logic [7:0] grant_count0, grant_count1;

  int n_vec = 0;
  int n_err = 0;

  // Reference state
  logic       m_bval;
  logic       m_prio;
  logic [7:0] m_cnt0, m_cnt1;
  logic [3:0] q[$];

  mux2_rr_arbiter #(.p_count_nbits(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .in0_val      (in0_val),
    .in0_rdy      (in0_rdy),
    .in0_msg      (in0_msg),
    .in1_val      (in1_val),
    .in1_rdy      (in1_rdy),
    .in1_msg      (in1_msg),
    .out_val      (out_val),
    .out_rdy      (out_rdy),
    .out_msg      (out_msg),
    .grant_count0 (grant_count0),
    .grant_count1 (grant_count1)
  );

  always #5 clk = ~clk;

  function automatic logic exp_rdy0();
    logic g;
    g = (in0_val && in1_val) ? m_prio : in1_val;
    return (!m_bval || out_rdy) && in0_val && !g;
  endfunction

  function automatic logic exp_rdy1();
    logic g;
    g = (in0_val && in1_val) ? m_prio : in1_val;
    return (!m_bval || out_rdy) && in1_val && g;
  endfunction

  function automatic logic [3:0] exp_msg();
    return (q.size() > 0) ? q[0] : 4'hx;
  endfunction

  // Advance one clock: update reference state from the current inputs,
  // push accepted messages and pop dequeued ones, then step past the edge.
  task automatic tick();
    logic x0, x1, deq;
    x0  = exp_rdy0();
    x1  = exp_rdy1();
    deq = m_bval && out_rdy;
    if (reset) begin
      m_bval = 1'b0; m_prio = 1'b0; m_cnt0 = '0; m_cnt1 = '0;
      q.delete();
    end else begin
      if (deq && q.size() > 0) q.delete(0);
      if (x0 || x1) begin
        q.push_back(x0 ? in0_msg : in1_msg);
        m_bval = 1'b1;
        m_prio = x0;
        if (x0) m_cnt0 = m_cnt0 + 8'd1;
        else    m_cnt1 = m_cnt1 + 8'd1;
      end else if (deq) begin
        m_bval = 1'b0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in0_val = 0; in1_val = 0; out_rdy = 0;
    in0_msg = '0; in1_msg = '0;
    tick();
    reset = 1'b0; #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_vec++;
    if (out_val !== 1'b0 || out_msg !== 4'b0000 || grant_count0 !== 8'd0 || grant_count1 !== 8'd0) begin
      n_err++;
      $display("FAIL reset: out_val=%b out_msg=%b cnt0=%0d cnt1=%0d, want 0/0000/0/0",
               out_val, out_msg, grant_count0, grant_count1);
    end
  endtask

  task automatic test_single();
    do_reset();
    in0_val = 1; in0_msg = 4'b1010; out_rdy = 1; #1;
    n_vec++;
    if (in0_rdy !== 1'b1 || in1_rdy !== 1'b0) begin
      n_err++; $display("FAIL single_rdy: in0_rdy=%b in1_rdy=%b, want 1/0", in0_rdy, in1_rdy);
    end
    tick();
    in0_val = 0; #1;
    n_vec++;
    if (out_val !== 1'b1 || out_msg !== 4'b1010 || out_msg !== exp_msg() || grant_count0 !== 8'd1) begin
      n_err++;
      $display("FAIL single_out: out_val=%b out_msg=%b cnt0=%0d, want 1/1010/1", out_val, out_msg, grant_count0);
    end
    tick();
    n_vec++;
    if (out_val !== 1'b0) begin
      n_err++; $display("FAIL single_drain: out_val=%b, want 0", out_val);
    end
  endtask

  task automatic test_alternate();
    logic [3:0] seq [4];
    seq = '{4'b1110, 4'b0111, 4'b1110, 4'b0111};
    do_reset();
    in0_val = 1; in1_val = 1; in0_msg = 4'b1110; in1_msg = 4'b0111; out_rdy = 1; #1;
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (in0_rdy !== exp_rdy0() || in1_rdy !== exp_rdy1() || (in0_rdy && in1_rdy)) begin
        n_err++; $display("FAIL alt_rdy[%0d]: in0_rdy=%b in1_rdy=%b, want %b/%b", i, in0_rdy, in1_rdy, exp_rdy0(), exp_rdy1());
      end
      tick();
      n_vec++;
      if (out_val !== 1'b1 || out_msg !== seq[i] || out_msg !== exp_msg()) begin
        n_err++; $display("FAIL alt_out[%0d]: out_val=%b out_msg=%b, want 1/%b", i, out_val, out_msg, seq[i]);
      end
    end
    n_vec++;
    if (grant_count0 !== 8'd2 || grant_count1 !== 8'd2) begin
      n_err++; $display("FAIL alt_cnt: cnt0=%0d cnt1=%0d, want 2/2", grant_count0, grant_count1);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] held;
    do_reset();
    in0_val = 1; in1_val = 1; in0_msg = 4'b1110; in1_msg = 4'b0111; out_rdy = 1; #1;
    tick();
    out_rdy = 0; #1;
    held = out_msg;
    n_vec++;
    if (held !== 4'b1110) begin
      n_err++; $display("FAIL bp_fill: out_msg=%b, want 1110", held);
    end
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (in0_rdy !== 1'b0 || in1_rdy !== 1'b0 || out_val !== 1'b1 || out_msg !== held ||
          grant_count0 !== 8'd1 || grant_count1 !== 8'd0) begin
        n_err++;
        $display("FAIL bp_stall[%0d]: rdy=%b%b out_val=%b out_msg=%b cnt=%0d/%0d, want 00/1/%b/1/0",
                 i, in0_rdy, in1_rdy, out_val, out_msg, grant_count0, grant_count1, held);
      end
      tick();
    end
    out_rdy = 1; #1;
    n_vec++;
    if (in1_rdy !== 1'b1 || in0_rdy !== 1'b0) begin
      n_err++; $display("FAIL bp_release_rdy: in0_rdy=%b in1_rdy=%b, want 0/1", in0_rdy, in1_rdy);
    end
    tick();
    n_vec++;
    if (out_val !== 1'b1 || out_msg !== 4'b0111 || out_msg !== exp_msg() || grant_count1 !== 8'd1) begin
      n_err++; $display("FAIL bp_release_out: out_val=%b out_msg=%b cnt1=%0d, want 1/0111/1", out_val, out_msg, grant_count1);
    end
  endtask

  task automatic test_prio();
    do_reset();
    in1_val = 1; out_rdy = 1;
    for (int i = 0; i < 3; i++) begin
      in1_msg = 4'(i + 3); #1;
      n_vec++;
      if (in1_rdy !== 1'b1 || in0_rdy !== 1'b0) begin
        n_err++; $display("FAIL prio_solo_rdy[%0d]: in0_rdy=%b in1_rdy=%b, want 0/1", i, in0_rdy, in1_rdy);
      end
      tick();
      n_vec++;
      if (out_msg !== 4'(i + 3) || out_msg !== exp_msg()) begin
        n_err++; $display("FAIL prio_solo_out[%0d]: out_msg=%b, want %b", i, out_msg, 4'(i + 3));
      end
    end
    in0_val = 1; in0_msg = 4'b1001; #1;
    n_vec++;
    if (in0_rdy !== 1'b1 || in1_rdy !== 1'b0) begin
      n_err++; $display("FAIL prio_contest: in0_rdy=%b in1_rdy=%b, want 1/0", in0_rdy, in1_rdy);
    end
    tick();
    n_vec++;
    if (out_msg !== 4'b1001 || grant_count0 !== 8'd1 || grant_count1 !== 8'd3) begin
      n_err++; $display("FAIL prio_out: out_msg=%b cnt=%0d/%0d, want 1001/1/3", out_msg, grant_count0, grant_count1);
    end
  endtask

  task automatic test_wrap();
    int bad = 0;
    do_reset();
    in0_val = 1; out_rdy = 1;
    for (int i = 0; i < 256; i++) begin
      in0_msg = 4'(i); #1;
      tick();
      if (out_msg !== 4'(i) || out_msg !== exp_msg() || grant_count0 !== m_cnt0) bad++;
      if (i == 254) begin
        n_vec++;
        if (grant_count0 !== 8'd255) begin
          n_err++; $display("FAIL wrap_max: cnt0=%0d, want 255", grant_count0);
        end
      end
    end
    n_vec++;
    if (bad != 0) begin
      n_err++; $display("FAIL wrap_stream: %0d cycles had wrong out_msg or count, want 0", bad);
    end
    n_vec++;
    if (grant_count0 !== 8'd0 || grant_count1 !== 8'd0) begin
      n_err++; $display("FAIL wrap_zero: cnt0=%0d cnt1=%0d, want 0/0", grant_count0, grant_count1);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    in0_val = 1; in0_msg = 4'b0110; out_rdy = 0; #1;
    tick();
    out_rdy = 1; in0_msg = 4'b1011; #1;
    n_vec++;
    if (out_val !== 1'b1 || in0_rdy !== 1'b1) begin
      n_err++; $display("FAIL rmid_setup: out_val=%b in0_rdy=%b, want 1/1", out_val, in0_rdy);
    end
    reset = 1; #1;
    tick();
    reset = 0; in0_val = 0; #1;
    n_vec++;
    if (out_val !== 1'b0 || out_msg !== 4'b0000 || grant_count0 !== 8'd0 || grant_count1 !== 8'd0) begin
      n_err++;
      $display("FAIL rmid: out_val=%b out_msg=%b cnt=%0d/%0d, want 0/0000/0/0", out_val, out_msg, grant_count0, grant_count1);
    end
    in0_val = 1; in1_val = 1; in0_msg = 4'b0001; in1_msg = 4'b0010; #1;
    n_vec++;
    if (in0_rdy !== 1'b1 || in1_rdy !== 1'b0) begin
      n_err++; $display("FAIL rmid_first_grant: in0_rdy=%b in1_rdy=%b, want 1/0", in0_rdy, in1_rdy);
    end
    tick();
  endtask

  initial begin
    reset = 1; in0_val = 0; in1_val = 0; out_rdy = 0; in0_msg = '0; in1_msg = '0;
    m_bval = 0; m_prio = 0; m_cnt0 = '0; m_cnt1 = '0;
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_prio();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
